// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg: PS/2 scancodes, arrow key indices, parser state encoding and arrow decoder
package ps2_keys_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [1:0] KEY_UP    = 2'd0;
  localparam logic [1:0] KEY_DOWN  = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  // returns {is_arrow, key_index}
  function automatic logic [2:0] decode_arrow(input logic [7:0] sc);
    return sc == SC_UP    ? {1'b1, KEY_UP}    :
           sc == SC_DOWN  ? {1'b1, KEY_DOWN}  :
           sc == SC_LEFT  ? {1'b1, KEY_LEFT}  :
           sc == SC_RIGHT ? {1'b1, KEY_RIGHT} : 3'b000;
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO of 3-bit key events
// Ports: clock, resetn (sync, active-low); push/din write; pop/dout read head;
// full, empty, count (0..DEPTH). Push while full succeeds only with a same-cycle pop.
module ps2_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [2:0]                 din,
  input  logic                       pop,
  output logic [2:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 byte stream -> arrow press/release events in a valid/ready FIFO
// Ports: clock, resetn (sync, active-low); received_data/received_data_en from PS/2 controller;
// enable gates FIFO pushes; evt_valid/evt_ready/evt_key/evt_make head handshake;
// key_held bitmap; fifo_count; sticky overflow.
// Macro KEY_REPEAT_FILTER_EN: drop makes for keys already held (typematic repeats).
module ps2_key_event_ctrl
  import ps2_keys_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [7:0]                  received_data,
  input  logic                        received_data_en,
  input  logic                        enable,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [1:0]                  evt_key,
  output logic                        evt_make,
  output logic [3:0]                  key_held,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  state_t        st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    held_q, held_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    arw, head;
  logic [1:0]    key;
  logic          ev, mk, push, pop, full, empty;
  assign arw = decode_arrow(received_data);
  assign key = arw[1:0];
  always_comb begin
    st_d  = st_q;
    ev    = 1'b0;
    mk    = 1'b0;
    // any byte leaves the current state, so the timer restarts from zero
    tmr_d = (st_q == ST_IDLE || received_data_en) ? '0 : tmr_q + TW'(1);
    if (received_data_en) begin
      ev   = arw[2];
      mk   = st_q == ST_IDLE || st_q == ST_EXT;
      st_d = arw[2] ? ST_IDLE :
             (received_data == SC_EXT && (st_q == ST_IDLE || st_q == ST_EXT)) ? ST_EXT :
             (received_data == SC_BRK && st_q == ST_IDLE) ? ST_BRK :
             (received_data == SC_BRK && st_q == ST_EXT) ? ST_EXT_BRK : ST_IDLE;
    end else if (st_q != ST_IDLE && tmr_q == TW'(PREFIX_TIMEOUT - 1)) begin
      st_d = ST_IDLE;
    end
    held_d = !ev ? held_q : mk ? held_q | (4'b1 << key) : held_q & ~(4'b1 << key);
    ovf_d  = ovf_q | (push & full & ~pop);
  end
`ifdef KEY_REPEAT_FILTER_EN
  assign push = ev & enable & ~(mk & held_q[key]);
`else
  assign push = ev & enable;
`endif
  assign pop = evt_valid & evt_ready;
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .din    ({key, mk}),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );
  assign evt_valid = ~empty;
  assign evt_key   = head[2:1];
  assign evt_make  = head[0];
  assign key_held  = held_q;
  assign overflow  = ovf_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      st_q   <= ST_IDLE;
      tmr_q  <= '0;
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences the raw PS/2 byte stream (received_data / received_data_en from the PS2_Controller) into clean arrow-key press/release events for the game logic.
- Parses E0 (extended) and F0 (break) prefixes with a prefix timeout, and tracks a held-key bitmap.
- Buffers decoded events in a small FIFO behind a valid/ready handshake, so the tile-judging logic consumes each key exactly once.
- Sits between the PS/2 controller and the hit-detection / scoring logic.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- PREFIX_TIMEOUT, 50000, clock cycles a prefix state may wait for its next byte before abandoning it (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous, active-low reset.
- received_data  in  8  scancode byte from the PS/2 controller.
- received_data_en  in  1  one-cycle strobe; received_data is valid this cycle.
- enable  in  1  when low, decoded events are not pushed to the FIFO; parsing and key_held still track.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_key  out  2  head key: 0 up, 1 down, 2 left, 3 right.
- evt_make  out  1  head event type: 1 press, 0 release.
- key_held  out  4  bit i set while key i is down.
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (resetn low at a clock edge): FSM=IDLE, timer=0, FIFO empty, evt_valid=0, key_held=0, overflow=0, fifo_count=0. A reset mid-sequence discards any partial prefix.
- Arrow codes: 8'h75 up, 8'h72 down, 8'h6B left, 8'h74 right. Accepted with or without an E0 prefix (keypad and extended arrows are equivalent).
- FSM advances only on cycles with received_data_en=1. States:
  - IDLE: E0 -> EXT; F0 -> BRK; arrow -> make event, stay IDLE; other bytes ignored.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (timer restarts); arrow -> make event, go to IDLE; other -> IDLE.
  - BRK: arrow -> break event, go to IDLE; any other byte -> IDLE, no event.
  - EXT_BRK: arrow -> break event, go to IDLE; any other byte -> IDLE, no event.
- Prefix timer:
  - Clears on entry to any prefix state (EXT, BRK, EXT_BRK) and counts every cycle while in one.
  - When it reaches PREFIX_TIMEOUT-1 with no byte that cycle, the FSM returns to IDLE with no event.
  - A byte arriving on the timeout cycle is processed normally; the byte takes precedence.
- Event effects on key_held:
  - Make: key_held[k] set.
  - Break: key_held[k] cleared.
  - key_held updates on the cycle after the byte, regardless of enable or FIFO state.
- Push rule: the event is pushed if enable=1. At most one push per cycle (one byte per cycle max).
- Latency: byte strobe at cycle N gives evt_valid=1 with the new event at N+1 when the FIFO was empty.
- Pop: occurs on any cycle with evt_valid & evt_ready. Order is FIFO; head outputs are driven from registered storage.
- Full and push with a pop the same cycle: both happen; count unchanged; no drop.
- Full and push with no pop: the event is dropped; overflow set until reset; key_held still updates.
- Empty and pop requested: ignored (evt_valid=0).
- Pointers wrap modulo FIFO_DEPTH. fifo_count range is 0..FIFO_DEPTH.
- evt_key and evt_make hold their last values when evt_valid=0; these values are don't-care to consumers.

Optional Feature:
- Macro: KEY_REPEAT_FILTER_EN.
- Defined: a make for a key whose key_held bit is already set (PS/2 typematic repeat) is not pushed. Breaks are always pushed.
- Undefined: every make is pushed, including repeats.
- key_held behaviour is identical in both builds.

Decomposition:
- Package ps2_keys_pkg holds:
  - Scancode constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT.
  - Key index constants KEY_UP..KEY_RIGHT.
  - FSM state encoding.
- Sub-module ps2_event_fifo: synchronous FIFO, 3-bit entries, parameterised depth, with push/pop/full/empty/count.
- The top level holds the FSM, the prefix timer, key_held and the repeat filter.

Test Plan:
- 8'h75 strobe, evt_ready=0 -> next cycle: evt_valid=1, evt_key=0, evt_make=1, key_held=4'b0001, fifo_count=1.
- E0,F0,6B (with left already held) -> one break event, evt_key=2, evt_make=0; key_held bit 2 clears; E0/F0 produce no events.
- F0, then idle for PREFIX_TIMEOUT cycles, then 8'h72 -> a make (not a break) for down; timer abandon verified.
- Five makes with FIFO_DEPTH=4 and evt_ready=0 -> fifo_count=4, overflow=1. Pop all -> up, down, left, right in order; fifth event lost.
- Full FIFO, push and pop in the same cycle -> count stays 4, overflow stays 0; assert resetn=0 mid E0 sequence -> all outputs return to reset values.
- With KEY_REPEAT_FILTER_EN: 74,74,74,F0,74 -> exactly 2 events (make, break). Without the macro -> 4 events.
